// File: rtl/rv32v_types_pkg.sv
// rtl/rv32v_types_pkg.sv - shared scalar writeback types and width constants
package rv32v_types_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic [REG_W-1:0] sel;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // x0 never counts as a match: it is neither a real source nor a real destination
  function automatic logic sel_match(input logic [REG_W-1:0] entry_sel,
                                     input logic [REG_W-1:0] chk_sel);
    return (chk_sel != '0) && (entry_sel == chk_sel);
  endfunction

endpackage

// File: rtl/rv32v_scalar_wb_arbiter_if.sv
// rtl/rv32v_scalar_wb_arbiter_if.sv - scalar/vector writeback, register-file and hazard signals
interface rv32v_scalar_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  import rv32v_types_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             s_wen;
  logic [REG_W-1:0] s_sel;
  logic [XLEN-1:0]  s_data;
  logic             s_stall;

  logic             v_wen;
  logic [REG_W-1:0] v_sel;
  logic [XLEN-1:0]  v_data;
  logic             v_full;

  logic             rf_wen;
  logic [REG_W-1:0] rf_sel;
  logic [XLEN-1:0]  rf_data;

  logic [REG_W-1:0] chk_rs1;
  logic [REG_W-1:0] chk_rs2;
  logic [REG_W-1:0] chk_rd;
  logic             hazard;

  logic [CNT_W-1:0] pending_cnt;
  logic             overflow;

  modport slave (
    input  s_wen, s_sel, s_data, v_wen, v_sel, v_data, chk_rs1, chk_rs2, chk_rd,
    output s_stall, v_full, rf_wen, rf_sel, rf_data, hazard, pending_cnt, overflow
  );

  modport master (
    output s_wen, s_sel, s_data, v_wen, v_sel, v_data, chk_rs1, chk_rs2, chk_rd,
    input  s_stall, v_full, rf_wen, rf_sel, rf_data, hazard, pending_cnt, overflow
  );

endinterface

// File: rtl/rv32v_scalar_wb_arbiter_fifo.sv
// rtl/rv32v_scalar_wb_arbiter_fifo.sv - sync FIFO of writeback entries exposing storage for the scoreboard
module rv32v_wb_fifo
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  wb_entry_t                i_push_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output wb_entry_t                o_entries [DEPTH],
  output logic [DEPTH-1:0]         o_valid,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is gated by o_valid everywhere it is observed, so it needs no reset
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign o_valid[g] = CNT_W'(PTR_W'(PTR_W'(g) - r_rd_ptr)) < r_count;
  end

  assign o_head    = r_mem[r_rd_ptr];
  assign o_entries = r_mem;
  assign o_count   = r_count;

endmodule

// File: rtl/rv32v_scalar_wb_arbiter.sv
// rtl/rv32v_scalar_wb_arbiter.sv - shares the scalar RF write port between scalar writeback and queued vector results
module rv32v_scalar_wb_arbiter
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                      CLK,
  input  logic                      nRST,
  rv32v_scalar_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  wb_entry_t        w_entries [DEPTH];
  wb_entry_t        w_head;
  wb_entry_t        w_push_entry;
  logic [DEPTH-1:0] w_valid;
  logic [CNT_W-1:0] w_count;
  logic             w_nonempty;
  logic             w_full;
  logic             w_force;
  logic             w_pop;
  logic             w_try_push;
  logic             w_push;
  logic             w_hazard;

  logic [SC_W-1:0]  r_starve;
  logic             r_overflow;

  assign w_nonempty   = (w_count != '0);
  assign w_full       = (w_count == CNT_W'(DEPTH));
  assign w_force      = (r_starve == STARVE_LIM) && w_nonempty;
  assign w_pop        = w_nonempty && (w_force || !bus.s_wen);
  assign w_try_push   = bus.v_wen && (bus.v_sel != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_push       = w_try_push && (!w_full || w_pop);
  assign w_push_entry = '{sel: bus.v_sel, data: bus.v_data};

  rv32v_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk        (CLK),
    .i_rst_n      (nRST),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_entries    (w_entries),
    .o_valid      (w_valid),
    .o_count      (w_count)
  );

  always_comb begin
    bus.rf_wen  = 1'b0;
    bus.rf_sel  = '0;
    bus.rf_data = '0;
    bus.s_stall = 1'b0;
    if (w_force) begin
      bus.rf_wen  = 1'b1;
      bus.rf_sel  = w_head.sel;
      bus.rf_data = w_head.data;
      bus.s_stall = bus.s_wen;
    end else if (bus.s_wen) begin
      bus.rf_wen  = 1'b1;
      bus.rf_sel  = bus.s_sel;
      bus.rf_data = bus.s_data;
    end else if (w_nonempty) begin
      bus.rf_wen  = 1'b1;
      bus.rf_sel  = w_head.sel;
      bus.rf_data = w_head.data;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
    end else if (w_pop || !w_nonempty) begin
      r_starve <= '0;
    end else if (bus.s_wen && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_overflow <= 1'b0;
    end else if (w_try_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Only registered entries are compared; a same-cycle push shows up next cycle
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (sel_match(w_entries[i].sel, bus.chk_rs1) ||
                         sel_match(w_entries[i].sel, bus.chk_rs2) ||
                         sel_match(w_entries[i].sel, bus.chk_rd))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign bus.hazard      = w_hazard;
  assign bus.v_full      = w_full;
  assign bus.pending_cnt = w_count;
  assign bus.overflow    = r_overflow;

endmodule

// File: doc/rv32v_scalar_wb_arbiter.md
Name: rv32v_scalar_wb_arbiter

Overview:
- Shares the single scalar register-file write port between the scalar pipeline writeback and scalar-destination results from the vector unit (vsetvl, vmv.x.s, vcpop.m and similar).
- Vector results are queued in a small FIFO and drained into idle write-port cycles.
- A starvation limit forces a drain by stalling scalar writeback.
- A pending-destination scoreboard flags RAW and WAW hazards against queued vector writes to the scalar decode stage.

Parameters:
- DEPTH, 4, vector result FIFO entries; power of 2, at least 2.
- STARVE_MAX, 8, consecutive cycles the scalar side may win while the FIFO is non-empty before a drain is forced.

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- s_wen  input  1  scalar writeback valid
- s_sel  input  5  scalar writeback destination
- s_data  input  32  scalar writeback data
- s_stall  output  1  scalar writeback held this cycle; scalar side keeps s_* stable
- v_wen  input  1  vector scalar-result write request
- v_sel  input  5  vector result destination
- v_data  input  32  vector result data
- v_full  output  1  FIFO full; vector unit must not assert v_wen
- rf_wen  output  1  register-file write enable
- rf_sel  output  5  register-file write destination
- rf_data  output  32  register-file write data
- chk_rs1, chk_rs2, chk_rd  input  5 each  decode-stage source and destination registers
- hazard  output  1  a checked register matches a pending FIFO destination
- pending_cnt  output  $clog2(DEPTH)+1  FIFO occupancy
- overflow  output  1  sticky error: a write was attempted while full

Behaviour:
- Reset (async, nRST low):
  - FIFO empty, pointers 0, starvation counter 0, overflow 0.
  - Hence v_full=0, hazard=0, pending_cnt=0, s_stall=0.
  - rf_wen follows s_wen combinationally.
  - Reset mid-operation discards queued entries.
- Enqueue:
  - v_wen=1 with v_sel!=0 and not full writes the tail at the clock edge.
  - v_sel==0 is discarded: no entry, no error.
  - Minimum latency from v_wen to rf_wen is 1 cycle; there is no same-cycle bypass.
- Write-port select (combinational):
  - force = (starve_cnt==STARVE_MAX) and FIFO non-empty.
  - If force: rf_* = FIFO head, pop, s_stall = s_wen.
  - Else if s_wen: rf_* = s_*, no pop, s_stall=0.
  - Else if FIFO non-empty: rf_* = head, pop.
  - Else rf_wen=0. rf_sel and rf_data are don't-care but driven 0.
  - s_wen with s_sel==0 is passed through unchanged; the register file ignores x0.
- Starvation counter:
  - Increments when FIFO non-empty, s_wen=1 and no pop.
  - Clears on any pop, and holds 0 while the FIFO is empty.
  - Saturates at STARVE_MAX.
- Simultaneous push and pop: both occur; occupancy unchanged. This is legal when full only if a pop happens that cycle.
- v_full = (count==DEPTH), derived from registered count; it does not look ahead to a same-cycle pop.
- v_wen while full with no pop that cycle: write dropped, overflow set until reset.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; count is tracked separately.
- hazard:
  - OR over valid entries of (entry_sel==chk_rs1 or ==chk_rs2 or ==chk_rd), with any chk_*==0 excluded.
  - The entry being popped this cycle still counts.
  - An entry being pushed this cycle does not count until the next cycle.
  - The scalar pipeline stalls decode on hazard, which preserves in-order writes to the same register.
- FIFO head register order is strict FIFO; no reordering.

Decomposition:
- Shared package rv32v_types_pkg gains wb_entry_t {logic [4:0] sel; logic [31:0] data;}.
- Width constants derive from parameters locally.
- One natural sub-module: rv32v_wb_fifo. It is a parameterised sync FIFO of wb_entry_t exposing entries, valid bits and count for the scoreboard compare.
- Arbitration, starvation counter and hazard compare stay in the top module.

Test Plan:
- Reset with s_wen=1, s_sel=5, s_data=0x11 -> rf_wen=1, rf_sel=5, rf_data=0x11; pending_cnt=0, hazard=0.
- v_wen with sel=7, data=0xAA at cycle 0, s_wen=0 -> cycle 1: rf_wen=1, rf_sel=7, rf_data=0xAA; cycle 2: pending_cnt=0.
- Enqueue x3=0x1; s_wen held 1 for 10 cycles -> scalar wins 8 cycles; cycle 9: s_stall=1, rf_sel=3, rf_data=0x1; scalar resumes at cycle 10.
- Fill 4 entries (x1..x4) with s_wen=1 (STARVE_MAX large) -> v_full=1. An extra v_wen -> overflow=1, pending_cnt=4, the 5th entry is never written.
- Queue x9; chk_rs1=9 -> hazard=1. Also chk_rd=9 -> hazard=1. chk_*=0 or 8 -> hazard=0. After drain -> hazard=0.
- v_wen with v_sel=0 -> pending_cnt stays 0, no rf write. Then push and pop in the same cycle at count 2 -> count stays 2 and data order is preserved across pointer wrap.
